fm_sb_readout_seq: RTL and testbench
====================================

Name: fm_sb_readout_seq

Overview:
- Sequencer for the FM spy-buffer bank.
- Arms on a software command, waits for a trigger, then freezes the selected spy buffers after a programmable post-trigger delay.
- Drains each frozen buffer in turn through the shared spy read port into a valid/ready output stream, with one header word per buffer, then releases freeze.
- Also runs a memory-init sweep that writes a fixed pattern to every address of the selected buffers.
- Sits between the FM control registers and the spy-buffer spy ports.

Parameters:
- SB_N, 29, number of spy buffers controlled.
- AXI_DW, 32, spy port and output stream data width.
- ADDR_W, 10, spy address width; buffer depth = 2**ADDR_W words.
- DLY_W, 16, width of the post-trigger delay.
- INIT_PATTERN, 32'h0fa5fa50, data written during init.

Ports:
- clk_hs  in  1  single clock for all logic.
- rst_hs  in  1  reset, synchronous, active-high.
- cmd_arm  in  1  one-cycle pulse: start capture sequence.
- cmd_init  in  1  one-cycle pulse: start init sweep.
- cmd_abort  in  1  one-cycle pulse: abort any sequence.
- sb_mask  in  SB_N  buffers taking part; sampled on cmd_arm/cmd_init.
- post_trig_dly  in  DLY_W  cycles from trigger to freeze; sampled on cmd_arm.
- trigger  in  1  capture trigger, level-sampled.
- freeze  out  SB_N  per-buffer freeze.
- sb_sel  out  $clog2(SB_N)  buffer index driven onto the shared spy port.
- sb_rd_en  out  1  spy read strobe.
- sb_addr  out  ADDR_W  spy address.
- sb_rd_data  in  AXI_DW  spy read data, valid 1 cycle after sb_rd_en.
- sb_wr_en  out  SB_N  per-buffer spy write enable.
- sb_wr_data  out  AXI_DW  spy write data.
- out_data  out  AXI_DW  readout stream data.
- out_vld  out  1  stream valid.
- out_rdy  in  1  stream ready.
- out_last  out  1  marks the last word of the last buffer.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at normal completion.
- err  out  1  one-cycle pulse on rejected command or abort.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, INIT, ARMED, DELAY, HDR, RD_REQ, RD_WAIT, WORD, RELEASE.
- IDLE + cmd_init:
  - mask==0 → err, stay IDLE; else → INIT.
  - Priority: cmd_abort > cmd_init > cmd_arm; a cmd_* pulse while busy is ignored (err pulses).
- INIT:
  - Each cycle: sb_wr_en = mask, sb_addr = counter, sb_wr_data = INIT_PATTERN.
  - After address 2**ADDR_W-1 → IDLE, done pulse.
  - Duration exactly 2**ADDR_W cycles.
- IDLE + cmd_arm:
  - mask==0 → err, stay IDLE; else latch mask and delay, → ARMED.
- ARMED, trigger==1:
  - delay==0 → freeze = mask on the next cycle, → HDR at the first masked index.
  - Otherwise → DELAY.
- DELAY: count 1..delay; freeze asserts exactly delay+1 cycles after the trigger cycle; → HDR.
- freeze stays = mask from HDR through the end of RELEASE entry; it deasserts in the cycle RELEASE → IDLE.
- HDR:
  - out_data = {8'hB0, 8'(index), 16'(2**ADDR_W)}, out_vld=1.
  - Hold until out_rdy; → RD_REQ with addr 0.
- RD_REQ: sb_rd_en=1, sb_sel=index, sb_addr=addr; → RD_WAIT.
- RD_WAIT: capture sb_rd_data into the output register; → WORD.
- WORD:
  - out_vld=1, data held stable until out_rdy.
  - On handshake: if addr < max → addr+1, RD_REQ.
  - Else advance to the next masked index → HDR; if none remain → RELEASE.
  - Peak throughput: 1 word per 3 cycles.
- out_last = 1 only on the final WORD of the highest masked index.
- RELEASE: freeze → 0, done pulse, → IDLE.
- Index scan: ascending; unmasked indices skipped with no cycles spent (priority-encode the next set bit above the current one).
- out_vld, once high, never drops without a handshake, except on abort or reset.
- cmd_abort in any non-IDLE state, next cycle:
  - freeze=0, sb_wr_en=0, out_vld=0; → IDLE.
  - err pulse; no done.
- Reset mid-sequence: identical to abort, but no err pulse.
- Trigger in IDLE/DELAY/readout states is ignored; only the first trigger in ARMED counts.

Decomposition:
- Shared package fm_sb_pkg:
  - state enum type.
  - header tag constant 8'hB0.
  - INIT_PATTERN default.
  - SB_N and AXI_DW defaults.
- Sub-module fm_sb_next_idx: combinational priority encoder returning the next set mask bit above the current index, plus a none-left flag. Used for the initial index and for advancing.

Test Plan:
- Init: ADDR_W=4, mask=0b101, cmd_init → 16 cycles with sb_wr_en=0b101, addr 0..15, data 0x0fa5fa50; done at cycle 17.
- Capture, zero delay: mask=0b010, trigger in ARMED → freeze=0b010 next cycle; header 0xB0010010, then 16 words = model memory; out_last on word 15; freeze drops; done.
- Delay + backpressure: delay=5, mask=0b1001; out_rdy toggling 1/0 → freeze at trigger+6 cycles; headers for idx 0 then 3; no word lost or duplicated; data stable while out_rdy=0.
- Empty-mask cmd_arm → err pulse, busy stays 0, freeze stays 0.
- Abort during WORD (idx 0, addr 7) → next cycle freeze=0, out_vld=0, err=1, state IDLE; a new cmd_arm is then accepted.
- rst_hs asserted during DELAY → all outputs 0 the next cycle; no done or err pulse.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the FM spy-buffer readout sequencer.
// Holds the sequencer state encoding, the header word layout and its tag.
package fm_sb_pkg;

    localparam int          SB_N_DEF         = 29;
    localparam int          AXI_DW_DEF       = 32;
    localparam logic [31:0] INIT_PATTERN_DEF = 32'h0fa5fa50;
    localparam logic [7:0]  HDR_TAG          = 8'hB0;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ARMED,
        DELAY,
        HDR,
        RD_REQ,
        RD_WAIT,
        WORD,
        RELEASE
    } seq_state_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [7:0]  idx;
        logic [15:0] len;
    } hdr_t;

    function automatic logic [31:0] hdr_word(input logic [7:0] idx, input int depth);
        hdr_t h;
        h.tag = HDR_TAG;
        h.idx = idx;
        h.len = 16'(depth);
        return h;
    endfunction

endpackage

// File: rtl/fm_sb_next_idx.sv
// Priority encoder: lowest set mask bit above cur (or at cur when incl is set).
// Purely combinational; none flags that no such bit exists.
module fm_sb_next_idx #(
    parameter int SB_N = 29,
    parameter int IW   = 5
) (
    input  logic [SB_N-1:0] mask,
    input  logic [IW-1:0]   cur,
    input  logic            incl,
    output logic [IW-1:0]   nxt,
    output logic            none
);

    // Scanning downwards lets the lowest qualifying bit win.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = SB_N - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                nxt  = IW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fm_sb_readout_seq.sv
// Spy-buffer sequencer: arm/trigger/freeze, per-buffer drain with header, init sweep.
// Latency: freeze lands post_trig_dly+1 cycles after trigger; readout runs 1 word per 3 cycles.
// Backpressure: out_vld/out_data hold until out_rdy; abort or reset drops the stream at once.
module fm_sb_readout_seq
    import fm_sb_pkg::*;
#(
    parameter int                SB_N         = SB_N_DEF,
    parameter int                AXI_DW       = AXI_DW_DEF,
    parameter int                ADDR_W       = 10,
    parameter int                DLY_W        = 16,
    parameter logic [AXI_DW-1:0] INIT_PATTERN = AXI_DW'(INIT_PATTERN_DEF)
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic                     cmd_arm,
    input  logic                     cmd_init,
    input  logic                     cmd_abort,
    input  logic [SB_N-1:0]          sb_mask,
    input  logic [DLY_W-1:0]         post_trig_dly,
    input  logic                     trigger,
    output logic [SB_N-1:0]          freeze,
    output logic [$clog2(SB_N)-1:0]  sb_sel,
    output logic                     sb_rd_en,
    output logic [ADDR_W-1:0]        sb_addr,
    input  logic [AXI_DW-1:0]        sb_rd_data,
    output logic [SB_N-1:0]          sb_wr_en,
    output logic [AXI_DW-1:0]        sb_wr_data,
    output logic [AXI_DW-1:0]        out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int              IW       = $clog2(SB_N);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    seq_state_t        state;
    logic [SB_N-1:0]   mask_q;
    logic [DLY_W-1:0]  dly_q;
    logic [DLY_W-1:0]  dly_cnt;
    logic [IW-1:0]     idx;
    logic [ADDR_W-1:0] addr;
    logic [IW-1:0]     first_idx;
    logic              first_none;
    logic [IW-1:0]     next_idx;
    logic              next_none;

    fm_sb_next_idx #(.SB_N(SB_N), .IW(IW)) u_first (
        .mask (mask_q),
        .cur  ('0),
        .incl (1'b1),
        .nxt  (first_idx),
        .none (first_none)
    );

    fm_sb_next_idx #(.SB_N(SB_N), .IW(IW)) u_next (
        .mask (mask_q),
        .cur  (idx),
        .incl (1'b0),
        .nxt  (next_idx),
        .none (next_none)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            state      <= IDLE;
            mask_q     <= '0;
            dly_q      <= '0;
            dly_cnt    <= '0;
            idx        <= '0;
            addr       <= '0;
            freeze     <= '0;
            sb_sel     <= '0;
            sb_rd_en   <= 1'b0;
            sb_addr    <= '0;
            sb_wr_en   <= '0;
            sb_wr_data <= '0;
            out_data   <= '0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            sb_rd_en <= 1'b0;
            if (state != IDLE && cmd_abort) begin
                state      <= IDLE;
                freeze     <= '0;
                sb_wr_en   <= '0;
                sb_wr_data <= '0;
                sb_addr    <= '0;
                out_vld    <= 1'b0;
                out_last   <= 1'b0;
                err        <= 1'b1;
            end else begin
                if (state != IDLE && (cmd_init || cmd_arm)) begin
                    err <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        // An abort with nothing running is a no-op and masks any other command.
                        if (!cmd_abort && (cmd_init || cmd_arm)) begin
                            if (sb_mask == '0) begin
                                err <= 1'b1;
                            end else if (cmd_init) begin
                                mask_q     <= sb_mask;
                                addr       <= '0;
                                sb_addr    <= '0;
                                sb_wr_en   <= sb_mask;
                                sb_wr_data <= INIT_PATTERN;
                                state      <= INIT;
                            end else begin
                                mask_q <= sb_mask;
                                dly_q  <= post_trig_dly;
                                state  <= ARMED;
                            end
                        end
                    end
                    INIT: begin
                        if (addr == ADDR_MAX) begin
                            sb_wr_en   <= '0;
                            sb_wr_data <= '0;
                            sb_addr    <= '0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            addr    <= addr + 1'b1;
                            sb_addr <= addr + 1'b1;
                        end
                    end
                    ARMED, DELAY: begin
                        if ((state == ARMED && trigger && dly_q == '0) ||
                            (state == DELAY && dly_cnt == dly_q)) begin
                            freeze <= mask_q;
                            if (first_none) begin
                                state <= RELEASE;
                            end else begin
                                idx      <= first_idx;
                                out_data <= AXI_DW'(hdr_word(8'(first_idx), DEPTH));
                                out_vld  <= 1'b1;
                                state    <= HDR;
                            end
                        end else if (state == ARMED && trigger) begin
                            dly_cnt <= DLY_W'(1);
                            state   <= DELAY;
                        end else if (state == DELAY) begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                    HDR: begin
                        if (out_rdy) begin
                            out_vld  <= 1'b0;
                            addr     <= '0;
                            sb_addr  <= '0;
                            sb_sel   <= idx;
                            sb_rd_en <= 1'b1;
                            state    <= RD_REQ;
                        end
                    end
                    RD_REQ: state <= RD_WAIT;
                    RD_WAIT: begin
                        out_data <= sb_rd_data;
                        out_vld  <= 1'b1;
                        out_last <= (addr == ADDR_MAX) && next_none;
                        state    <= WORD;
                    end
                    WORD: begin
                        if (out_rdy) begin
                            out_vld  <= 1'b0;
                            out_last <= 1'b0;
                            if (addr != ADDR_MAX) begin
                                addr     <= addr + 1'b1;
                                sb_addr  <= addr + 1'b1;
                                sb_rd_en <= 1'b1;
                                state    <= RD_REQ;
                            end else if (!next_none) begin
                                idx      <= next_idx;
                                out_data <= AXI_DW'(hdr_word(8'(next_idx), DEPTH));
                                out_vld  <= 1'b1;
                                state    <= HDR;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        freeze <= '0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fm_sb_readout_seq.sv
// Directed bench for fm_sb_readout_seq with a stream scoreboard built from the buffer list.
module tb_fm_sb_readout_seq;

    localparam int SB_N   = 29;
    localparam int AXI_DW = 32;
    localparam int ADDR_W = 4;
    localparam int DLY_W  = 16;
    localparam int IW     = $clog2(SB_N);

    logic              clk_hs = 1'b0;
    logic              rst_hs = 1'b1;
    logic              cmd_arm = 1'b0;
    logic              cmd_init = 1'b0;
    logic              cmd_abort = 1'b0;
    logic              trigger = 1'b0;
    logic              out_rdy = 1'b1;
    logic [SB_N-1:0]   sb_mask = '0;
    logic [DLY_W-1:0]  post_trig_dly = '0;
    logic [AXI_DW-1:0] sb_rd_data = '0;

    logic [SB_N-1:0]   freeze;
    logic [IW-1:0]     sb_sel;
    logic              sb_rd_en;
    logic [ADDR_W-1:0] sb_addr;
    logic [SB_N-1:0]   sb_wr_en;
    logic [AXI_DW-1:0] sb_wr_data;
    logic [AXI_DW-1:0] out_data;
    logic              out_vld;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    fm_sb_readout_seq #(
        .SB_N(SB_N), .AXI_DW(AXI_DW), .ADDR_W(ADDR_W), .DLY_W(DLY_W),
        .INIT_PATTERN(32'h0fa5fa50)
    ) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .cmd_arm(cmd_arm), .cmd_init(cmd_init),
        .cmd_abort(cmd_abort), .sb_mask(sb_mask), .post_trig_dly(post_trig_dly),
        .trigger(trigger), .freeze(freeze), .sb_sel(sb_sel), .sb_rd_en(sb_rd_en),
        .sb_addr(sb_addr), .sb_rd_data(sb_rd_data), .sb_wr_en(sb_wr_en),
        .sb_wr_data(sb_wr_data), .out_data(out_data), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clk_hs = ~clk_hs;

    int              n_total = 0;
    int              n_bad   = 0;
    int              hs_cnt  = 0;
    bit              scb_en  = 1'b0;
    bit              rdy_tog = 1'b0;
    bit              prev_stall = 1'b0;
    logic [31:0]     prev_data = '0;
    logic [SB_N-1:0] m_mask = '0;
    logic [32:0]     exp_q[$];
    logic [31:0]     got_w[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spy-buffer contents as seen through the read port.
    function automatic logic [31:0] mem_word(input int i, input int a);
        return {8'hD0 ^ 8'(i * 7), 8'(i), 8'(a), 8'(a * 13 + i)};
    endfunction

    // Read data is valid only in the cycle after the strobe; otherwise garbage.
    always @(posedge clk_hs) begin
        if (sb_rd_en) sb_rd_data <= mem_word(int'(sb_sel), int'(sb_addr));
        else          sb_rd_data <= 32'hDEADBEEF;
    end

    initial forever begin
        @(posedge clk_hs);
        #1;
        out_rdy = rdy_tog ? ~out_rdy : 1'b1;
    end

    // Expected stream: per masked buffer in ascending order, a header then every word.
    task automatic build_exp(input logic [SB_N-1:0] m);
        int hi;
        hi = -1;
        exp_q.delete();
        hs_cnt = 0;
        for (int i = 0; i < SB_N; i++) if (m[i]) hi = i;
        for (int i = 0; i < SB_N; i++) begin
            if (m[i]) begin
                exp_q.push_back({1'b0, 8'hB0, 8'(i), 16'(2 ** ADDR_W)});
                for (int a = 0; a < 2 ** ADDR_W; a++)
                    exp_q.push_back({(i == hi) && (a == 2 ** ADDR_W - 1), mem_word(i, a)});
            end
        end
        m_mask = m;
    endtask

    always @(negedge clk_hs) begin
        if (scb_en) begin
            if (out_vld) begin
                chk("freeze_hold", freeze, m_mask);
                if (prev_stall) chk("data_stable", out_data, prev_data);
                if (out_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL extra_word: got %0h expected no more words", out_data);
                    end else begin
                        chk("stream_word", {out_last, out_data}, exp_q.pop_front());
                        if (hs_cnt < 2) got_w[hs_cnt] = out_data;
                        hs_cnt++;
                    end
                end
                prev_stall = !out_rdy;
                prev_data  = out_data;
            end else begin
                if (prev_stall) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL vld_drop: got out_vld 0 expected 1 until handshake");
                end
                prev_stall = 1'b0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk_hs);
        #1;
    endtask

    task automatic arm(input logic [SB_N-1:0] m, input logic [DLY_W-1:0] d);
        sb_mask = m;
        post_trig_dly = d;
        cmd_arm = 1'b1;
        step();
        cmd_arm = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int cyc);
        cyc = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk_hs);
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int first;
        int found;
        int quiet_bad;

        repeat (3) step();
        rst_hs = 1'b0;
        @(negedge clk_hs);
        chk("rst_freeze", freeze, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_wr_en", sb_wr_en, 0);
        chk("rst_rd_en", sb_rd_en, 0);
        chk("rst_done_err", {done, err, out_last}, 0);

        // Init sweep: 16 write cycles, done on the 17th.
        sb_mask = 29'b101;
        cmd_init = 1'b1;
        step();
        cmd_init = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_hs);
            chk("init_wr_en", sb_wr_en, 29'b101);
            chk("init_addr", sb_addr, k);
            chk("init_data", sb_wr_data, 32'h0fa5fa50);
            chk("init_no_done", done, 0);
        end
        @(negedge clk_hs);
        chk("init_done", done, 1);
        chk("init_wr_off", sb_wr_en, 0);
        chk("init_idle", busy, 0);

        // Empty mask is rejected.
        arm('0, '0);
        @(negedge clk_hs);
        chk("empty_err", err, 1);
        chk("empty_busy", busy, 0);
        chk("empty_freeze", freeze, 0);
        @(negedge clk_hs);
        chk("empty_err_pulse", err, 0);

        // Zero-delay capture of buffer 1.
        build_exp(29'b010);
        arm(29'b010, 16'd0);
        @(negedge clk_hs);
        chk("z_armed_busy", busy, 1);
        chk("z_armed_freeze", freeze, 0);
        scb_en = 1'b1;
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        @(negedge clk_hs);
        chk("z_freeze_next", freeze, 29'b010);
        chk("z_hdr_vld", out_vld, 1);
        step();
        cmd_init = 1'b1;
        step();
        cmd_init = 1'b0;
        @(negedge clk_hs);
        chk("busy_cmd_err", err, 1);
        wait_done(400, cyc);
        chk("z_done_seen", cyc >= 0, 1);
        chk("z_freeze_drop", freeze, 0);
        chk("z_idle", busy, 0);
        chk("z_all_words", exp_q.size(), 0);
        chk("z_hs_cnt", hs_cnt, 17);
        chk("z_hdr_literal", got_w[0], 32'hB0010010);
        chk("z_word0_literal", got_w[1], 32'hD7010001);
        scb_en = 1'b0;

        // Delay 5 with backpressure, buffers 0 and 3; trigger held a few cycles.
        build_exp(29'b1001);
        rdy_tog = 1'b1;
        arm(29'b1001, 16'd5);
        scb_en = 1'b1;
        trigger = 1'b1;
        step();
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) trigger = 1'b0;
            @(negedge clk_hs);
            if (freeze != 0 && first == 0) first = k;
        end
        chk("d_freeze_lat", first, 6);
        wait_done(800, cyc);
        chk("d_done_seen", cyc >= 0, 1);
        chk("d_all_words", exp_q.size(), 0);
        chk("d_hs_cnt", hs_cnt, 34);
        chk("d_hdr_literal", got_w[0], 32'hB0000010);
        chk("d_freeze_drop", freeze, 0);
        scb_en = 1'b0;
        rdy_tog = 1'b0;
        step();
        step();

        // Abort while word 7 of buffer 0 is on the stream.
        build_exp(29'b1);
        arm(29'b1, 16'd0);
        scb_en = 1'b1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_hs);
            if (sb_rd_en && sb_addr == 4'd7 && sb_sel == '0) begin
                found = 1;
                break;
            end
        end
        chk("ab_reach_addr7", found, 1);
        scb_en = 1'b0;
        step();
        step();
        cmd_abort = 1'b1;
        @(negedge clk_hs);
        chk("ab_word_vld", out_vld, 1);
        chk("ab_word7", out_data, 32'hD000075B);
        step();
        cmd_abort = 1'b0;
        @(negedge clk_hs);
        chk("ab_freeze", freeze, 0);
        chk("ab_vld", out_vld, 0);
        chk("ab_err", err, 1);
        chk("ab_idle", busy, 0);
        chk("ab_no_done", done, 0);
        arm(29'b100, 16'd0);
        @(negedge clk_hs);
        chk("ab_rearm_busy", busy, 1);
        chk("ab_rearm_no_err", err, 0);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        @(negedge clk_hs);
        chk("ab_armed_err", err, 1);
        chk("ab_armed_idle", busy, 0);

        // Reset during the post-trigger delay.
        arm(29'b11, 16'd20);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (3) step();
        @(negedge clk_hs);
        chk("r_in_delay", {busy, freeze}, {1'b1, 29'b0});
        rst_hs = 1'b1;
        step();
        rst_hs = 1'b0;
        @(negedge clk_hs);
        chk("r_freeze", freeze, 0);
        chk("r_busy", busy, 0);
        chk("r_done_err", {done, err}, 0);
        chk("r_vld", out_vld, 0);
        quiet_bad = 0;
        repeat (30) begin
            @(negedge clk_hs);
            if (freeze != 0 || done || err || busy) quiet_bad++;
        end
        chk("r_quiet_after", quiet_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
